button_press_decoder: RTL and testbench
=======================================

Name: button_press_decoder

Overview:
Input-side counterpart of the board LED drivers: reads a raw mechanical pushbutton and turns it into clean, single-cycle events for the rest of the design. The block synchronises and debounces the button, then decodes each press as short or long. A typical consumer is an LED mode controller that changes blink rate on a short press and toggles on/off on a long press.

Parameters:
- CLK_HZ, 125_000_000, system clock frequency. Informational; used only to derive the defaults below.
- DEBOUNCE_CYCLES, 1_250_000, consecutive stable cycles required to accept a level change (10 ms at 125 MHz). Must be >= 2.
- LONG_CYCLES, 125_000_000, debounced hold time that classifies a press as long (1 s). Must be > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- btn  in  1  raw pushbutton, active-high, asynchronous to clk, bouncy.
- btn_level  out  1  debounced button level.
- press_pulse  out  1  one-cycle pulse on an accepted press.
- release_pulse  out  1  one-cycle pulse on an accepted release.
- short_pulse  out  1  one-cycle pulse on release when the hold was shorter than LONG_CYCLES.
- long_pulse  out  1  one-cycle pulse when the hold reaches LONG_CYCLES, while the button is still held.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. Every flop clears while rst_n = 0. All outputs are 0 and the FSM is in IDLE.
- Reset mid-press: the press is discarded. After rst_n deasserts with btn held high, a fresh debounce starts and produces a new press_pulse.
- Synchroniser: btn passes through two flops (btn_s1, btn_s2), both reset to 0. All logic uses btn_s2 only.
- Debounce counter db_cnt, width $clog2(DEBOUNCE_CYCLES):
  - Clears on every cycle where btn_s2 == btn_level, so any bounce restarts the count.
  - Increments on every cycle where btn_s2 != btn_level.
  - When it would reach DEBOUNCE_CYCLES, btn_level flips on that edge and db_cnt clears.
- Press latency: with btn stable high, btn_level and press_pulse rise exactly DEBOUNCE_CYCLES+2 rising edges after the first edge that samples btn = 1. Release latency is identical.
- All outputs are registered. The pulses are exactly one cycle wide and mutually exclusive, except that release_pulse and short_pulse coincide.
- FSM states:
  - IDLE: btn_level = 0. On an accepted rise, assert press_pulse, clear hold_cnt, go to HELD.
  - HELD: hold_cnt increments each cycle.
    - When hold_cnt reaches LONG_CYCLES-1, assert long_pulse and go to LONG_HELD.
    - On an accepted fall, assert release_pulse and short_pulse, go to IDLE.
    - If the fall and the long threshold land on the same cycle, the fall wins: short_pulse, no long_pulse.
  - LONG_HELD: on an accepted fall, assert release_pulse only (no short_pulse), go to IDLE.
- hold_cnt: width $clog2(LONG_CYCLES). It saturates and never wraps, so an arbitrarily long hold gives exactly one long_pulse.
- Glitches shorter than DEBOUNCE_CYCLES cycles in either direction produce no events and leave btn_level unchanged.
- Only one transition is possible per DEBOUNCE_CYCLES window, so no back-to-back press/release can occur.

Decomposition:
- Shared package (board_io_pkg):
  - FSM state enum {IDLE, HELD, LONG_HELD}.
  - Default timing constants derived from CLK_HZ (DEBOUNCE_MS = 10, LONG_MS = 1000).
- Sub-module sync_2ff: generic two-flop synchroniser with async active-low reset. Reusable for the other board switches.

Test Plan (simulate with DEBOUNCE_CYCLES = 4, LONG_CYCLES = 20):
- Reset: rst_n = 0 with btn = 1 -> all outputs 0. Release reset -> press_pulse for one cycle 6 edges later, btn_level = 1.
- Bounce rejection: btn toggles 1/0 every 2 cycles for 30 cycles, then stays 0 -> no pulses, btn_level stays 0.
- Short press: btn high for 10 cycles -> press_pulse at edge 6. Release -> release_pulse and short_pulse in the same cycle 6 edges after the fall. No long_pulse.
- Long press: btn high for 100 cycles -> press_pulse, then exactly one long_pulse 20 cycles after btn_level rises. On release, release_pulse with short_pulse = 0.
- Tie case: arrange the accepted fall on the cycle hold_cnt = 19 -> short_pulse and release_pulse, no long_pulse, FSM back in IDLE.
- Reset mid-hold: assert rst_n = 0 in LONG_HELD -> outputs 0 immediately (asynchronous). Deassert with btn = 0 -> no pulses follow.

Source files
------------

// File: rtl/board_io_pkg.sv
// Shared types and default timing for the board input blocks.
// Defaults assume a 125 MHz system clock.
package board_io_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HELD,
        LONG_HELD
    } btn_state_t;

    localparam int DEF_CLK_HZ  = 125_000_000;
    localparam int DEBOUNCE_MS = 10;
    localparam int LONG_MS     = 1000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs.
// Both stages clear on reset.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/button_press_decoder.sv
// Debounces a raw pushbutton and decodes press, release,
// short-press and long-press events as one-cycle pulses.
module button_press_decoder
    import board_io_pkg::*;
#(
    parameter int CLK_HZ          = DEF_CLK_HZ,
    parameter int DEBOUNCE_CYCLES = CLK_HZ / 1000 * DEBOUNCE_MS,
    parameter int LONG_CYCLES     = CLK_HZ / 1000 * LONG_MS
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_pulse,
    output logic long_pulse
);

    localparam int DBW = $clog2(DEBOUNCE_CYCLES);
    localparam int HW  = $clog2(LONG_CYCLES);
    localparam logic [DBW-1:0] DB_MAX = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0]  H_MAX  = HW'(LONG_CYCLES - 1);

    logic           btn_s2;
    logic [DBW-1:0] db_cnt_q, db_cnt_d;
    logic           level_q, level_d;
    logic [HW-1:0]  hold_q, hold_d;
    btn_state_t     state_q, state_d;
    logic           press_q, press_d;
    logic           rel_q, rel_d;
    logic           short_q, short_d;
    logic           long_q, long_d;
    logic           rise, fall;

    sync_2ff #(.WIDTH(1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (btn),
        .q_o   (btn_s2)
    );

    // Any sample matching the current level restarts the count.
    always_comb begin
        db_cnt_d = '0;
        level_d  = level_q;
        if (btn_s2 != level_q) begin
            if (db_cnt_q == DB_MAX) begin
                level_d = btn_s2;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    assign rise = level_d & ~level_q;
    assign fall = ~level_d & level_q;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        short_d = 1'b0;
        long_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    press_d = 1'b1;
                    hold_d  = '0;
                    state_d = HELD;
                end
            end
            HELD: begin
                if (hold_q != H_MAX) begin
                    hold_d = hold_q + 1'b1;
                end
                // A release on the threshold cycle counts as short.
                if (fall) begin
                    rel_d   = 1'b1;
                    short_d = 1'b1;
                    state_d = IDLE;
                end else if (hold_q == H_MAX) begin
                    long_d  = 1'b1;
                    state_d = LONG_HELD;
                end
            end
            LONG_HELD: begin
                if (fall) begin
                    rel_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt_q <= '0;
            level_q  <= 1'b0;
            hold_q   <= '0;
            state_q  <= IDLE;
            press_q  <= 1'b0;
            rel_q    <= 1'b0;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
        end else begin
            db_cnt_q <= db_cnt_d;
            level_q  <= level_d;
            hold_q   <= hold_d;
            state_q  <= state_d;
            press_q  <= press_d;
            rel_q    <= rel_d;
            short_q  <= short_d;
            long_q   <= long_d;
        end
    end

    assign btn_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = rel_q;
    assign short_pulse   = short_q;
    assign long_pulse    = long_q;

endmodule

// File: tb/tb_button_press_decoder.sv
// Directed bench for button_press_decoder with short
// debounce and long-press thresholds.
module tb_button_press_decoder;
    import board_io_pkg::*;

    localparam int DB = 4;
    localparam int LC = 20;

    logic clk = 1'b0;
    logic rst_n;
    logic btn;
    logic btn_level, press_pulse, release_pulse;
    logic short_pulse, long_pulse;
    logic [4:0] outs;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       b;
        logic [4:0] exp;
    } vec_t;

    vec_t tbl[17];

    button_press_decoder #(
        .CLK_HZ          (1000),
        .DEBOUNCE_CYCLES (DB),
        .LONG_CYCLES     (LC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn           (btn),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .short_pulse   (short_pulse),
        .long_pulse    (long_pulse)
    );

    // {level, press, release, short, long}
    assign outs = {btn_level, press_pulse, release_pulse,
                   short_pulse, long_pulse};

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int idx,
                       input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %b expected %b",
                     nm, idx, act, exp);
        end
    endtask

    // Button high for edges 1..n_high, low afterwards.
    task automatic run_seq(input string nm, input int n_high,
                           input int n_total);
        int p, r, l;
        logic [4:0] e;
        p = DB + 2;
        r = n_high + DB + 2;
        l = p + LC;
        for (int k = 1; k <= n_total; k++) begin
            btn = (k <= n_high);
            tick();
            e = '0;
            e[4] = (k >= p) && (k < r);
            e[3] = (k == p);
            e[2] = (k == r);
            e[1] = (k == r) && (r <= l);
            e[0] = (k == l) && (r > l);
            chk(nm, k, outs, e);
        end
    endtask

    initial begin
        tbl[0]  = '{b: 1'b1, exp: 5'b00000};
        tbl[1]  = '{b: 1'b1, exp: 5'b00000};
        tbl[2]  = '{b: 1'b1, exp: 5'b00000};
        tbl[3]  = '{b: 1'b1, exp: 5'b00000};
        tbl[4]  = '{b: 1'b1, exp: 5'b00000};
        tbl[5]  = '{b: 1'b1, exp: 5'b11000};
        tbl[6]  = '{b: 1'b1, exp: 5'b10000};
        tbl[7]  = '{b: 1'b1, exp: 5'b10000};
        tbl[8]  = '{b: 1'b1, exp: 5'b10000};
        tbl[9]  = '{b: 1'b1, exp: 5'b10000};
        tbl[10] = '{b: 1'b0, exp: 5'b10000};
        tbl[11] = '{b: 1'b0, exp: 5'b10000};
        tbl[12] = '{b: 1'b0, exp: 5'b10000};
        tbl[13] = '{b: 1'b0, exp: 5'b10000};
        tbl[14] = '{b: 1'b0, exp: 5'b10000};
        tbl[15] = '{b: 1'b0, exp: 5'b00110};
        tbl[16] = '{b: 1'b0, exp: 5'b00000};

        rst_n = 1'b0;
        btn   = 1'b1;
        tick();
        tick();
        tick();
        chk("reset", 0, outs, 5'b00000);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            btn = tbl[i].b;
            tick();
            chk("short_tbl", i + 1, outs, tbl[i].exp);
        end

        for (int k = 0; k < 30; k++) begin
            btn = ((k / 2) % 2) == 0;
            tick();
            chk("bounce", k, outs, 5'b00000);
        end
        btn = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("bounce_quiet", k, outs, 5'b00000);
        end

        run_seq("long", 100, 110);
        run_seq("tie", 20, 30);
        chk("tie_idle", 0, 5'(dut.state_q), 5'(IDLE));
        run_seq("pre_tie", 19, 28);
        run_seq("post_tie", 21, 32);

        for (int k = 1; k <= 30; k++) begin
            btn = 1'b1;
            tick();
        end
        chk("long_held", 0, 5'(dut.state_q), 5'(LONG_HELD));
        chk("long_held_lvl", 0, outs, 5'b10000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst", 0, outs, 5'b00000);
        btn = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 15; k++) begin
            tick();
            chk("post_rst", k, outs, 5'b00000);
        end
        chk("post_rst_idle", 0, 5'(dut.state_q), 5'(IDLE));

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
